base_aserial: RTL
=================

Name: base_aserial

Overview:
- Transmit side of the valid/ready/end beat-stream framing used across the base library.
- Accepts one wide packet word per handshake, plus a beat count.
- Emits the packet as a sequence of narrow beats on a valid/ready stream, with o_e marking the last beat.
- Downstream first-beat detectors see a well-formed stream: exactly one o_e per packet, no gaps mid-packet while downstream is ready.

Parameters:
- width, 64, bits per output beat.
- nbeats, 4, maximum beats per packet; input word is width*nbeats bits.
- cwidth, 2, width of the beat count/index; must satisfy 2**cwidth >= nbeats.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous reset, active-high.
- i_v  input  1  input packet valid.
- i_r  output  1  input ready; packet accepted on i_v & i_r.
- i_d  input  width*nbeats  packet data; beat k is i_d[k*width +: width].
- i_cnt  input  cwidth  number of beats minus one.
- o_v  output  1  output beat valid.
- o_r  input  1  output beat ready; beat transferred on o_v & o_r.
- o_d  output  width  output beat data.
- o_e  output  1  last beat of packet, qualified by o_v.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is asynchronous and active-high; all state clears immediately on assertion.
  - Reset values: o_v=0, o_e=0, o_d=0, beat index=0, stored count=0, state IDLE.
  - i_r=0 while reset is high.
- States:
  - IDLE: no packet held; o_v=0.
  - SEND: packet held in an internal width*nbeats register; o_v=1.
- Ready: i_r = ~reset & (IDLE | (SEND & o_v & o_r & o_e)). This allows back-to-back packets with no bubble.
- Accept (i_v & i_r):
  - Capture i_d and the count, with the count saturated: i_cnt > nbeats-1 is stored as nbeats-1.
  - Beat index <= 0; state <= SEND.
  - Latency: first beat is presented on the cycle after acceptance.
- Output data:
  - o_d = stored beat[index], beat 0 first.
  - o_e = (index == stored count).
  - o_d and o_e are held stable while o_v & ~o_r.
- Transfer (o_v & o_r):
  - Not last beat: index <= index+1.
  - Last beat with no new accept: state <= IDLE, index <= 0.
  - Last beat with a simultaneous accept: load the new packet and stay in SEND; o_v remains 1 on the next cycle.
- Single-beat packet (count 0): o_e=1 on the only beat.
- The index never exceeds the stored count; there is no wrap past nbeats-1.
- While in SEND, i_d changes are ignored.
- Reset mid-packet: the packet is discarded, no o_e is emitted, and the block returns to IDLE immediately.
- o_v never deasserts mid-packet; gaps arise only from o_r backpressure.

Optional Feature:
- Macro: BASE_ASERIAL_FIRST_EN.
- Defined:
  - Adds output port o_f (1 bit), = o_v & (index == 0), asserted on the first beat of each packet.
  - o_f is 0 on reset.
  - On a single-beat packet, o_f and o_e are both 1.
- Undefined: port o_f is absent. Downstream derives first-beat from o_v/o_r/o_e framing.

Test Plan:
- Reset released; i_v=1, i_cnt=3, i_d = {64'h3, 64'h2, 64'h1, 64'h0}, o_r=1 -> beats 0,1,2,3 on four consecutive cycles starting the cycle after accept; o_e only on 3; i_r=0 during beats 0-2.
- Back-to-back: packet A (cnt 1) then packet B (cnt 0) held valid, o_r=1 -> o_v continuously 1 for 3 cycles with data A0, A1, B0; o_e on A1 and B0; B accepted in the cycle A1 transfers.
- Backpressure: cnt=2, o_r toggles 1,0,0,1,1 -> o_d/o_e held during o_r=0 cycles; all 3 beats delivered in order, none duplicated or dropped.
- Saturation: nbeats=4, i_cnt=3 versus an overridden build with nbeats=3, cwidth=2, i_cnt=3 -> 3 beats emitted, o_e on beat 2.
- Async reset asserted mid-packet after beat 1 of 4 -> o_v and o_e drop without waiting for clk; after release, the next packet starts at beat 0 with the correct data.
- BASE_ASERIAL_FIRST_EN defined: cnt=0 packet -> o_f=1 and o_e=1 on the same beat. cnt=2 packet -> o_f=1 only on beat 0.

Source files
------------

// File: rtl/base_aserial.sv
// Packet-to-beat serializer: one width*nbeats word in, 1..nbeats narrow beats out with o_e on the last.
// Optional first-beat flag o_f when BASE_ASERIAL_FIRST_EN is defined.
module base_aserial #(
    parameter int width  = 64,
    parameter int nbeats = 4,
    parameter int cwidth = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_v,
    output logic                      i_r,
    input  logic [width*nbeats-1:0]   i_d,
    input  logic [cwidth-1:0]         i_cnt,
    output logic                      o_v,
    input  logic                      o_r,
    output logic [width-1:0]          o_d,
`ifdef BASE_ASERIAL_FIRST_EN
    output logic                      o_f,
`endif
    output logic                      o_e
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [cwidth-1:0] MAX_IDX = cwidth'(nbeats - 1);

    state_t                          state_q, state_d;
    logic [nbeats-1:0][width-1:0]    data_q, data_d;
    logic [cwidth-1:0]               idx_q, idx_d;
    logic [cwidth-1:0]               cnt_q, cnt_d;
    logic                            last;
    logic                            xfer;
    logic                            accept;

    assign o_v    = (state_q == SEND);
    assign last   = (idx_q == cnt_q);
    assign o_e    = o_v & last;
    assign o_d    = data_q[idx_q];
    assign xfer   = o_v & o_r;
    // Ready on the last transfer lets the next packet load with no idle cycle.
    assign i_r    = ~reset & ((state_q == IDLE) | (xfer & last));
    assign accept = i_v & i_r;

`ifdef BASE_ASERIAL_FIRST_EN
    assign o_f = o_v & (idx_q == '0);
`else
    // Without o_f, the first beat is the one after an o_e transfer or after IDLE.
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (accept) begin
            data_d  = i_d;
            cnt_d   = (i_cnt > MAX_IDX) ? MAX_IDX : i_cnt;
            idx_d   = '0;
            state_d = SEND;
        end else if (xfer) begin
            if (last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + cwidth'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the packet register is cleared too, so o_d reads 0 out of reset rather than X.
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
